// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline boundary register with valid/ready, stall, flush and optional skid buffer
module pipe_stage_reg #(
   parameter int DATA_W      = 232,
   parameter int CTRL_W      = 9,
   parameter int SKID        = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [STALL_CNT_W-1:0] stall_cnt
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) stall_cnt <= '0;
      else if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
   if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
      state_t              state;
      logic [DATA_W-1:0]   skid_data;
      logic [CTRL_W-1:0]   skid_ctrl;
      // skid validity is implied by FULL; in_ready is registered from the next state
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
         end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            skid_ctrl <= '0;
         end else begin
            case (state)
               EMPTY: if (in_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_ctrl  <= in_ctrl;
                  state     <= BUSY;
               end
               BUSY: if (in_valid && out_ready) begin
                  out_data <= in_data;
                  out_ctrl <= in_ctrl;
               end else if (in_valid) begin
                  skid_data <= in_data;
                  skid_ctrl <= in_ctrl;
                  state     <= FULL;
                  in_ready  <= 1'b0;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  out_ctrl  <= '0;
                  state     <= EMPTY;
               end
               FULL: if (out_ready) begin
                  out_data  <= skid_data;
                  out_ctrl  <= skid_ctrl;
                  skid_data <= '0;
                  skid_ctrl <= '0;
                  state     <= BUSY;
                  in_ready  <= 1'b1;
               end
               default: begin
                  state     <= EMPTY;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  out_ctrl  <= '0;
               end
            endcase
         end
   end else begin : g_single
      assign in_ready = !out_valid || out_ready;
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
         end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
         end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
         end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for skid, saturating-counter and single-register variants
module tb_pipe_stage_reg;
   localparam int DW = 232;
   localparam int CW = 9;
   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, out_ready, flush;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [DW-1:0] a_out_data, b_out_data, c_out_data;
   logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
   logic [15:0]   a_stall, c_stall;
   logic [3:0]    b_stall;
   int            vectors = 0;
   int            miscompares = 0;
   logic [31:0]   sbq[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.SKID(1), .STALL_CNT_W(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall));
   pipe_stage_reg #(.SKID(1), .STALL_CNT_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall));
   pipe_stage_reg #(.SKID(0), .STALL_CNT_W(16)) dut_c (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall));

   function automatic logic [DW-1:0] mk_data(input logic [31:0] t);
      return {t ^ 32'hA5A5_0000, 168'd0, t};
   endfunction

   function automatic logic [CW-1:0] mk_ctrl(input logic [31:0] t);
      return {1'b1, t[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      logic [31:0] t;
      if (a_out_valid && out_ready) begin
         chk("sb_nonempty", 256'(sbq.size() != 0), 256'd1);
         if (sbq.size() != 0) begin
            t = sbq.pop_front();
            chk("out_data", 256'(a_out_data), 256'(mk_data(t)));
            chk("out_ctrl", 256'(a_out_ctrl), 256'(mk_ctrl(t)));
         end
      end
   endtask

   // one cycle: drive, sample at the falling edge, then advance past the rising edge
   task automatic step(input logic v, input logic [31:0] t, input logic ordy, input logic fl, input logic acc);
      in_valid  = v;
      in_data   = mk_data(t);
      in_ctrl   = mk_ctrl(t);
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      sb_check();
      if (!a_out_valid) chk("ctrl_idle_zero", 256'(a_out_ctrl), 256'd0);
      if (v && !fl) chk("in_ready", 256'(a_in_ready), 256'(acc));
      if (acc) sbq.push_back(t);
      if (fl) sbq.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0; in_ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 256'(a_out_valid), 256'd0);
      chk("rst_in_ready", 256'(a_in_ready), 256'd1);
      chk("rst_out_data", 256'(a_out_data), 256'd0);
      chk("rst_stall", 256'(a_stall), 256'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      // back-to-back streaming
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
         chk("stream_valid", 256'(a_out_valid), 256'd1);
         chk("stream_latency", 256'(a_out_data), 256'(mk_data(32'(i))));
      end
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("stream_drained", 256'(a_out_valid), 256'd0);
      // backpressure: A to main, B to skid, C waits
      step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
      chk("bp_head_held", 256'(a_out_data), 256'(mk_data(32'h10)));
      chk("bp_stall3", 256'(a_stall), 256'd3);
      step(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h12, 1'b1, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("bp_empty", 256'(a_out_valid), 256'd0);
      chk("bp_stall_hold", 256'(a_stall), 256'd3);
      // flush while FULL with a new entry offered
      step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h21, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
      chk("fl_out_valid", 256'(a_out_valid), 256'd0);
      chk("fl_out_ctrl", 256'(a_out_ctrl), 256'd0);
      chk("fl_in_ready", 256'(a_in_ready), 256'd1);
      chk("fl_stall_kept", 256'(a_stall), 256'd5);
      step(1'b1, 32'h23, 1'b1, 1'b1, 1'b0);
      chk("fl_empty_discard", 256'(a_out_valid), 256'd0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      // asynchronous reset with main and skid occupied
      step(1'b1, 32'h28, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h29, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 256'(a_out_valid), 256'd0);
      chk("arst_out_ctrl", 256'(a_out_ctrl), 256'd0);
      chk("arst_in_ready", 256'(a_in_ready), 256'd1);
      chk("arst_stall", 256'(a_stall), 256'd0);
      chk("arst_stall_b", 256'(b_stall), 256'd0);
      sbq.delete();
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      // saturation of the 4-bit counter
      step(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
      repeat (15) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("sat_reach", 256'(b_stall), 256'd15);
      repeat (5) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("sat_hold", 256'(b_stall), 256'd15);
      chk("sat_wide", 256'(a_stall), 256'd20);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      // single-register variant: combinational in_ready
      step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
      chk("s0_valid", 256'(c_out_valid), 256'd1);
      chk("s0_data", 256'(c_out_data), 256'(mk_data(32'h40)));
      chk("s0_ready_low", 256'(c_in_ready), 256'd0);
      step(1'b1, 32'h41, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b1; in_data = mk_data(32'h41); in_ctrl = mk_ctrl(32'h41); out_ready = 1'b0;
      @(negedge clk);
      chk("s0_ready_stall", 256'(c_in_ready), 256'd0);
      out_ready = 1'b1;
      #1;
      chk("s0_ready_comb", 256'(c_in_ready), 256'd1);
      sb_check();
      @(posedge clk);
      #1;
      chk("s0_load_data", 256'(c_out_data), 256'(mk_data(32'h41)));
      chk("s0_load_ctrl", 256'(c_out_ctrl), 256'(mk_ctrl(32'h41)));
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      chk("s0_drain_valid", 256'(c_out_valid), 256'd0);
      chk("s0_drain_ctrl", 256'(c_out_ctrl), 256'd0);
      chk("sb_final_empty", 256'(sbq.size()), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
